// File: rtl/alu_accumulator_if.sv
// Command/result bundle between the switch/key input layer and the accumulator ALU.
// The master issues commands; the slave reports handshake status and the accumulator.
interface alu_accumulator_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0]   a;
    logic [2:0]         op;
    logic               start;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] acc;
    logic               zero;

    modport master (
        output a, op, start,
        input  busy, done, acc, zero
    );

    modport slave (
        input  a, op, start,
        output busy, done, acc, zero
    );
endinterface

// File: rtl/alu_accumulator.sv
// Accumulator ALU: single-cycle ops combine operand a with acc's low half,
// plus a WIDTH-iteration shift-add multiplier behind a start/busy/done handshake.
module alu_accumulator #(
    parameter int WIDTH = 4
) (
    input  logic              clock,
    input  logic              resetn,
    alu_accumulator_if.slave  bus
);
    localparam int ACC_W = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_SUB    = 3'b001;
    localparam logic [2:0] OP_LOGIC  = 3'b010;
    localparam logic [2:0] OP_ANY    = 3'b011;
    localparam logic [2:0] OP_ALL    = 3'b100;
    localparam logic [2:0] OP_CONCAT = 3'b101;
    localparam logic [2:0] OP_MUL    = 3'b110;

    localparam logic [ACC_W-1:0] ANY_PATTERN = {1'b1, {(ACC_W-2){1'b0}}, 1'b1};
    localparam logic [ACC_W-1:0] ALL_PATTERN = {1'b0, {(ACC_W-2){1'b1}}, 1'b0};

    logic [0:0]       state_q,  state_d;
    logic [ACC_W-1:0] acc_q,    acc_d;
    logic             done_q,   done_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [ACC_W-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [ACC_W-1:0] prod_q,   prod_d;

    logic [WIDTH-1:0] opb;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic [ACC_W-1:0] partial;

    assign opb     = acc_q[WIDTH-1:0];
    assign sum_w   = {1'b0, bus.a} + {1'b0, opb};
    assign diff_w  = {1'b0, bus.a} - {1'b0, opb};
    assign partial = prod_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;

        if (state_q == S_IDLE) begin
            if (bus.start) begin
                done_d = 1'b1;
                case (bus.op)
                    OP_ADD:    acc_d = {{(WIDTH-1){1'b0}}, sum_w};
                    OP_SUB:    acc_d = {{(WIDTH-1){diff_w[WIDTH]}}, diff_w};
                    OP_LOGIC:  acc_d = {bus.a ^ opb, bus.a | opb};
                    OP_ANY:    acc_d = (|{bus.a, opb}) ? ANY_PATTERN : '0;
                    OP_ALL:    acc_d = (&{bus.a, opb}) ? ALL_PATTERN : '0;
                    OP_CONCAT: acc_d = {opb, bus.a};
                    OP_MUL: begin
                        // acc is untouched here; the product lands only after the last iteration
                        done_d   = 1'b0;
                        mcand_d  = {{WIDTH{1'b0}}, bus.a};
                        mplier_d = opb;
                        prod_d   = '0;
                        cnt_d    = CNT_W'(WIDTH);
                        state_d  = S_MUL;
                    end
                    default:   acc_d = acc_q;
                endcase
            end
        end else begin
            prod_d   = partial;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                acc_d   = partial;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    // Multiplier datapath is only meaningful while in S_MUL, so it carries no reset
    always_ff @(posedge clock) begin
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
        prod_q   <= prod_d;
    end

    assign bus.busy = (state_q == S_MUL);
    assign bus.done = done_q;
    assign bus.acc  = acc_q;
    assign bus.zero = (acc_q == '0);
endmodule

// File: tb/tb_alu_accumulator.sv
// Directed bench for alu_accumulator at WIDTH=4 with hand-computed expected values.
module tb_alu_accumulator;
    localparam int W = 4;

    logic clock;
    logic resetn;
    int   checks;
    int   failures;
    int   busy_cnt;

    alu_accumulator_if #(.WIDTH(W)) bus ();

    alu_accumulator #(.WIDTH(W)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic [2:0] op, input logic [W-1:0] a);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        resetn   = 1'b0;
        cmd(3'b000, 4'hF);

        // Reset overrides a pending ADD
        cyc(); cyc();
        chk("rst_acc",  16'(bus.acc), 16'h00);
        chk("rst_busy", 16'(bus.busy), 16'h0);
        chk("rst_done", 16'(bus.done), 16'h0);
        chk("rst_zero", 16'(bus.zero), 16'h1);

        resetn = 1'b1;
        cmd(3'b101, 4'hA);
        cyc();
        chk("concat_acc",  16'(bus.acc), 16'h0A);
        chk("concat_done", 16'(bus.done), 16'h1);
        chk("concat_zero", 16'(bus.zero), 16'h0);
        bus.start = 1'b0;
        cyc();
        chk("concat_done_drop", 16'(bus.done), 16'h0);
        chk("concat_hold", 16'(bus.acc), 16'h0A);

        cmd(3'b000, 4'h9);
        cyc();
        chk("add_acc", 16'(bus.acc), 16'h13);
        cmd(3'b001, 4'h1);
        cyc();
        chk("sub_acc",  16'(bus.acc), 16'hFE);
        chk("sub_done", 16'(bus.done), 16'h1);
        bus.start = 1'b0;
        cyc();

        // MUL handshake: 0x0F * 0xF
        resetn = 1'b0;
        cyc();
        resetn = 1'b1;
        cmd(3'b000, 4'hF);
        cyc();
        chk("mul_pre_acc", 16'(bus.acc), 16'h0F);
        cmd(3'b110, 4'hF);
        cyc();
        busy_cnt = 0;
        chk("mul_busy0", 16'(bus.busy), 16'h1);
        chk("mul_done0", 16'(bus.done), 16'h0);
        chk("mul_acc0",  16'(bus.acc), 16'h0F);
        cmd(3'b101, 4'h3);
        for (int i = 0; i < 8 && bus.busy; i++) begin
            busy_cnt++;
            chk("mul_acc_stable", 16'(bus.acc), 16'h0F);
            chk("mul_no_done", 16'(bus.done), 16'h0);
            cyc();
            bus.start = 1'b0;
        end
        chk("mul_busy_cycles", 16'(busy_cnt), 16'd4);
        chk("mul_result", 16'(bus.acc), 16'hE1);
        chk("mul_done",   16'(bus.done), 16'h1);
        chk("mul_busy_end", 16'(bus.busy), 16'h0);
        cyc();
        chk("mul_done_single", 16'(bus.done), 16'h0);
        chk("mul_ignored_start", 16'(bus.acc), 16'hE1);

        // Reset mid-MUL: 0x7 * 0x3 aborted
        resetn = 1'b0;
        cyc();
        resetn = 1'b1;
        cmd(3'b000, 4'h3);
        cyc();
        cmd(3'b110, 4'h7);
        cyc();
        chk("abort_busy", 16'(bus.busy), 16'h1);
        bus.start = 1'b0;
        cyc();
        resetn = 1'b0;
        cyc();
        resetn = 1'b1;
        chk("abort_acc",  16'(bus.acc), 16'h00);
        chk("abort_busy_clr", 16'(bus.busy), 16'h0);
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("abort_no_done", 16'(bus.done), 16'h0);
            chk("abort_acc_kept", 16'(bus.acc), 16'h00);
        end

        // Logic ops
        cmd(3'b011, 4'h0);
        cyc();
        chk("any_zero", 16'(bus.acc), 16'h00);
        chk("any_done", 16'(bus.done), 16'h1);
        cmd(3'b000, 4'hF);
        cyc();
        cmd(3'b100, 4'hF);
        cyc();
        chk("all_set", 16'(bus.acc), 16'h7E);
        bus.start = 1'b0;
        resetn = 1'b0;
        cyc();
        resetn = 1'b1;
        cmd(3'b000, 4'hF);
        cyc();
        cmd(3'b010, 4'h5);
        cyc();
        chk("logic_acc", 16'(bus.acc), 16'hAF);
        bus.start = 1'b0;
        cyc();
        cmd(3'b111, 4'h3);
        cyc();
        chk("hold_acc",  16'(bus.acc), 16'hAF);
        chk("hold_done", 16'(bus.done), 16'h1);
        cmd(3'b011, 4'h0);
        cyc();
        chk("any_set", 16'(bus.acc), 16'h81);
        cmd(3'b100, 4'hF);
        cyc();
        chk("all_clear", 16'(bus.acc), 16'h00);
        chk("all_clear_zero", 16'(bus.zero), 16'h1);

        // Throughput: ADD/HOLD alternating with start held
        for (int i = 0; i < 6; i++) begin
            cmd((i % 2 == 0) ? 3'b000 : 3'b111, 4'h1);
            cyc();
            chk("thru_done", 16'(bus.done), 16'h1);
            chk("thru_acc",  16'(bus.acc), 16'(i / 2 + 1));
        end

        // MUL accepted in the same cycle as the previous MUL's done
        cmd(3'b110, 4'h5);
        cyc();
        bus.start = 1'b0;
        chk("b2b_busy_a", 16'(bus.busy), 16'h1);
        cyc(); cyc(); cyc();
        chk("b2b_busy_late", 16'(bus.busy), 16'h1);
        cyc();
        chk("b2b_first_acc",  16'(bus.acc), 16'h0F);
        chk("b2b_first_done", 16'(bus.done), 16'h1);
        chk("b2b_first_busy", 16'(bus.busy), 16'h0);
        cmd(3'b110, 4'h2);
        cyc();
        bus.start = 1'b0;
        chk("b2b_accept_busy", 16'(bus.busy), 16'h1);
        chk("b2b_accept_done", 16'(bus.done), 16'h0);
        chk("b2b_accept_acc",  16'(bus.acc), 16'h0F);
        cyc(); cyc(); cyc(); cyc();
        chk("b2b_second_acc",  16'(bus.acc), 16'h1E);
        chk("b2b_second_done", 16'(bus.done), 16'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
